pwm_meter: RTL and testbench
============================

// Module: pwm_meter
// PURPOSE
//  Downstream monitor for the PWM generator: samples its io_out line and measures the
//  high time and period of each PWM cycle in clock cycles.
//  Publishes one measurement per period over a valid/ready handshake and flags
//  stuck-high/stuck-low lines and lost results. Used for closed-loop duty checking.
// PARAMETERS
//  MEAS_W   9   width of high/period counters; saturate at 2^MEAS_W-1 (511)
// PORTS
//  clock        in   1       single clock, all logic on rising edge
//  reset        in   1       synchronous, active-high
//  io_in        in   1       PWM line (generator io_out), same clock domain
//  io_en        in   1       measurement enable
//  io_clr       in   1       one-cycle pulse: clear sticky flags
//  io_ready     in   1       consumer accepts result
//  io_valid     out  1       result registers hold an unconsumed measurement
//  io_high      out  MEAS_W  high cycles of last complete period
//  io_period    out  MEAS_W  total cycles of last complete period (rise to rise)
//  io_stuck_hi  out  1       sticky: high counter saturated
//  io_stuck_lo  out  1       sticky: low/arming counter saturated
//  io_overrun   out  1       sticky: completed measurement dropped
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, prev_in=0.
//  prev_in <= io_in each cycle. rise = io_in & !prev_in; fall = !io_in & prev_in.
//  FSM (pwm_state_t):
//   IDLE  : io_en=1 -> ARMED (cnt cleared).
//   ARMED : wait for rise; rise -> HIGH, hcnt=1. No result from first edge.
//           lcnt counts waiting cycles; saturate -> set stuck_lo, stay ARMED.
//   HIGH  : io_in=1 -> hcnt++ (saturating); fall -> LOW, lcnt=1.
//           hcnt reaches 2^MEAS_W-1 -> set stuck_hi, -> ARMED.
//   LOW   : io_in=0 -> lcnt++; lcnt saturates -> set stuck_lo, -> ARMED.
//           rise -> complete: high=hcnt, period=hcnt+lcnt; -> HIGH, hcnt=1 (back-to-back).
//  io_en=0 in any state -> IDLE next cycle; in-flight measurement discarded;
//   pending io_valid/result kept until handshake.
//  Period sum computed MEAS_W+1 wide; result saturates to 2^MEAS_W-1.
//  Latency: io_valid and result registers updated on the clock edge that samples the
//   rise; visible the cycle after the rise cycle.
//  Handshake: transfer when io_valid & io_ready; io_valid drops next cycle unless
//   a new completion loads simultaneously (then stays 1 with new data, no overrun).
//   Results stable while io_valid & !io_ready.
//  Completion while io_valid & !io_ready: new result dropped, old held, overrun <= 1.
//  io_clr clears stuck_hi/stuck_lo/overrun; a set event in the same cycle wins.
//  Reset mid-measurement: everything returns to reset values the next cycle.
// STRUCTURE
//  Shared package pwm_pkg: pwm_state_t enum {IDLE,ARMED,HIGH,LOW}; MEAS_W_DEF=9.
//  One sub-module pwm_edge_det: prev_in register plus rise/fall outputs.
//  Top holds FSM, saturating counters, result/flag registers.
// TESTING
//  1 PWM T=9,duty=3,inc=1, io_ready=1 -> every 10 cycles io_valid pulse, high=4, period=10.
//  2 duty=0,T=255 -> high=1, period=256; duty changes to 7 -> next full period high=8.
//  3 duty>=T (line stays 1) -> stuck_hi after 511 high cycles, no io_valid.
//    PWM inc=0 (line 0) -> stuck_lo set.
//  4 io_ready=0 over two completions -> first result held, overrun=1.
//    io_clr pulse -> overrun=0.
//  5 io_valid&io_ready on the same cycle as a completion -> io_valid stays 1,
//    new values, overrun=0.
//  6 reset or io_en=0 mid-HIGH -> IDLE.
//    Re-enable: first rise gives no result, second rise gives a correct result.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM line meter.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } pwm_state_t;

  localparam int MEAS_W_DEF = 9;

endpackage

// File: rtl/pwm_meter_if.sv
// Line input, control and result handshake of the PWM meter.
interface pwm_meter_if
  import pwm_pkg::*;
#(
  parameter int MEAS_W = MEAS_W_DEF
);
  logic              io_in;
  logic              io_en;
  logic              io_clr;
  logic              io_ready;
  logic              io_valid;
  logic [MEAS_W-1:0] io_high;
  logic [MEAS_W-1:0] io_period;
  logic              io_stuck_hi;
  logic              io_stuck_lo;
  logic              io_overrun;

  modport master (
    output io_in, io_en, io_clr, io_ready,
    input  io_valid, io_high, io_period, io_stuck_hi, io_stuck_lo, io_overrun
  );

  modport slave (
    input  io_in, io_en, io_clr, io_ready,
    output io_valid, io_high, io_period, io_stuck_hi, io_stuck_lo, io_overrun
  );
endinterface

// File: rtl/pwm_edge_det.sv
// Registers the previous line level and flags rising/falling transitions.
module pwm_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic d_in,
  output logic rise,
  output logic fall
);
  logic prev_q, prev_d;

  always_comb prev_d = d_in;

  always_ff @(posedge clock) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign rise = d_in & ~prev_q;
  assign fall = ~d_in & prev_q;
endmodule

// File: rtl/pwm_meter.sv
// Measures high time and rise-to-rise period of a PWM line, one result per period
// over valid/ready, with sticky stuck-line and overrun flags.
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int MEAS_W = MEAS_W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  pwm_meter_if.slave   bus
);
  localparam logic [MEAS_W-1:0] MAX    = '1;
  localparam logic [MEAS_W-1:0] MAX_M1 = MAX - 1'b1;
  localparam logic [MEAS_W-1:0] ONE    = 1;

  pwm_state_t        state_q, state_d;
  logic [MEAS_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [MEAS_W-1:0] high_q, high_d, period_q, period_d;
  logic              valid_q, valid_d;
  logic              stuck_hi_q, stuck_hi_d, stuck_lo_q, stuck_lo_d, overrun_q, overrun_d;
  logic              rise, fall, complete, set_hi, set_lo, set_ovr;
  logic [MEAS_W:0]   period_sum;
  logic [MEAS_W-1:0] period_sat;

  pwm_edge_det u_edge (
    .clock (clock),
    .reset (reset),
    .d_in  (bus.io_in),
    .rise  (rise),
    .fall  (fall)
  );

  // One extra bit catches high+low overflowing the result width.
  assign period_sum = {1'b0, hcnt_q} + {1'b0, lcnt_q};
  assign period_sat = period_sum[MEAS_W] ? MAX : period_sum[MEAS_W-1:0];

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    complete = 1'b0;
    set_hi   = 1'b0;
    set_lo   = 1'b0;
    if (!bus.io_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
          hcnt_d  = '0;
          lcnt_d  = '0;
        end
        ARMED: begin
          if (rise) begin
            state_d = HIGH;
            hcnt_d  = ONE;
          end else if (lcnt_q != MAX) begin
            lcnt_d = lcnt_q + 1'b1;
            set_lo = (lcnt_q == MAX_M1);
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            lcnt_d  = ONE;
          end else if (hcnt_q == MAX_M1) begin
            hcnt_d  = MAX;
            lcnt_d  = '0;
            set_hi  = 1'b1;
            state_d = ARMED;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            complete = 1'b1;
            state_d  = HIGH;
            hcnt_d   = ONE;
          end else if (lcnt_q == MAX_M1) begin
            lcnt_d  = MAX;
            set_lo  = 1'b1;
            state_d = ARMED;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion that lands on a handshake cycle reloads instead of dropping.
  always_comb begin
    valid_d  = valid_q;
    high_d   = high_q;
    period_d = period_q;
    set_ovr  = 1'b0;
    if (complete && valid_q && !bus.io_ready) begin
      set_ovr = 1'b1;
    end else if (complete) begin
      valid_d  = 1'b1;
      high_d   = hcnt_q;
      period_d = period_sat;
    end else if (valid_q && bus.io_ready) begin
      valid_d = 1'b0;
    end
    stuck_hi_d = (stuck_hi_q & ~bus.io_clr) | set_hi;
    stuck_lo_d = (stuck_lo_q & ~bus.io_clr) | set_lo;
    overrun_d  = (overrun_q  & ~bus.io_clr) | set_ovr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      valid_q    <= 1'b0;
      high_q     <= '0;
      period_q   <= '0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      valid_q    <= valid_d;
      high_q     <= high_d;
      period_q   <= period_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.io_valid    = valid_q;
  assign bus.io_high     = high_q;
  assign bus.io_period   = period_q;
  assign bus.io_stuck_hi = stuck_hi_q;
  assign bus.io_stuck_lo = stuck_lo_q;
  assign bus.io_overrun  = overrun_q;
endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench for pwm_meter: line patterns with hand-computed high/period results.
module tb_pwm_meter;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pwm_meter_if #(.MEAS_W(9)) bus ();

  pwm_meter #(.MEAS_W(9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    bus.io_in = v;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.io_in = 1'b0; bus.io_en = 1'b0; bus.io_clr = 1'b0; bus.io_ready = 1'b0;
    do_reset();
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period, bus.io_stuck_hi, bus.io_stuck_lo, bus.io_overrun} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b h=%0d p=%0d shi=%b slo=%b ovr=%b want all 0",
               bus.io_valid, bus.io_high, bus.io_period, bus.io_stuck_hi, bus.io_stuck_lo, bus.io_overrun);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.io_en = 1'b1; bus.io_ready = 1'b1;
    tick();
    drive(1'b0, 2);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1);
      total++;
      if (k == 0 && bus.io_valid !== 1'b0) begin
        bad++;
        $display("FAIL basic_first_rise: got valid=%b want 0", bus.io_valid);
      end else if (k > 0 && {bus.io_valid, bus.io_high, bus.io_period} !== {1'b1, 9'd4, 9'd10}) begin
        bad++;
        $display("FAIL basic_result%0d: got v=%b h=%0d p=%0d want v=1 h=4 p=10",
                 k, bus.io_valid, bus.io_high, bus.io_period);
      end
      drive(1'b1, 1);
      total++;
      if (bus.io_valid !== 1'b0) begin
        bad++;
        $display("FAIL basic_valid_drop%0d: got valid=%b want 0", k, bus.io_valid);
      end
      drive(1'b1, 2);
      drive(1'b0, 6);
    end
  endtask

  task automatic test_long_period();
    do_reset();
    bus.io_en = 1'b1; bus.io_ready = 1'b1;
    tick();
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b0, 255);
    drive(1'b1, 1);
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period} !== {1'b1, 9'd1, 9'd256}) begin
      bad++;
      $display("FAIL long_duty0: got v=%b h=%0d p=%0d want v=1 h=1 p=256",
               bus.io_valid, bus.io_high, bus.io_period);
    end
    drive(1'b1, 7);
    drive(1'b0, 248);
    drive(1'b1, 1);
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period} !== {1'b1, 9'd8, 9'd256}) begin
      bad++;
      $display("FAIL long_duty7: got v=%b h=%0d p=%0d want v=1 h=8 p=256",
               bus.io_valid, bus.io_high, bus.io_period);
    end
  endtask

  task automatic test_stuck();
    do_reset();
    bus.io_en = 1'b1; bus.io_ready = 1'b1;
    tick();
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b1, 509);
    total++;
    if (bus.io_stuck_hi !== 1'b0) begin
      bad++;
      $display("FAIL stuck_hi_early: got %b want 0 at 510 high cycles", bus.io_stuck_hi);
    end
    drive(1'b1, 1);
    total++;
    if ({bus.io_stuck_hi, bus.io_valid} !== 2'b10) begin
      bad++;
      $display("FAIL stuck_hi_set: got shi=%b v=%b want shi=1 v=0", bus.io_stuck_hi, bus.io_valid);
    end
    do_reset();
    bus.io_in = 1'b0;
    tick();
    drive(1'b0, 510);
    total++;
    if (bus.io_stuck_lo !== 1'b0) begin
      bad++;
      $display("FAIL stuck_lo_early: got %b want 0", bus.io_stuck_lo);
    end
    drive(1'b0, 1);
    total++;
    if ({bus.io_stuck_lo, bus.io_stuck_hi, bus.io_valid} !== 3'b100) begin
      bad++;
      $display("FAIL stuck_lo_set: got slo=%b shi=%b v=%b want slo=1 shi=0 v=0",
               bus.io_stuck_lo, bus.io_stuck_hi, bus.io_valid);
    end
    bus.io_clr = 1'b1;
    tick();
    bus.io_clr = 1'b0;
    total++;
    if (bus.io_stuck_lo !== 1'b0) begin
      bad++;
      $display("FAIL stuck_lo_clr: got %b want 0", bus.io_stuck_lo);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.io_en = 1'b1; bus.io_ready = 1'b0;
    tick();
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 1);
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period, bus.io_overrun} !== {1'b1, 9'd3, 9'd8, 1'b0}) begin
      bad++;
      $display("FAIL ovr_first: got v=%b h=%0d p=%0d ovr=%b want v=1 h=3 p=8 ovr=0",
               bus.io_valid, bus.io_high, bus.io_period, bus.io_overrun);
    end
    drive(1'b1, 4);
    drive(1'b0, 3);
    drive(1'b1, 1);
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period, bus.io_overrun} !== {1'b1, 9'd3, 9'd8, 1'b1}) begin
      bad++;
      $display("FAIL ovr_held: got v=%b h=%0d p=%0d ovr=%b want v=1 h=3 p=8 ovr=1",
               bus.io_valid, bus.io_high, bus.io_period, bus.io_overrun);
    end
    bus.io_clr = 1'b1;
    tick();
    bus.io_clr = 1'b0;
    total++;
    if ({bus.io_overrun, bus.io_valid} !== 2'b01) begin
      bad++;
      $display("FAIL ovr_clr: got ovr=%b v=%b want ovr=0 v=1", bus.io_overrun, bus.io_valid);
    end
    bus.io_ready = 1'b1;
    tick();
    total++;
    if (bus.io_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovr_drain: got valid=%b want 0", bus.io_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.io_en = 1'b1; bus.io_ready = 1'b0;
    tick();
    drive(1'b0, 2);
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 1);
    drive(1'b1, 1);
    drive(1'b0, 3);
    bus.io_ready = 1'b1;
    drive(1'b1, 1);
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period, bus.io_overrun} !== {1'b1, 9'd2, 9'd5, 1'b0}) begin
      bad++;
      $display("FAIL b2b_reload: got v=%b h=%0d p=%0d ovr=%b want v=1 h=2 p=5 ovr=0",
               bus.io_valid, bus.io_high, bus.io_period, bus.io_overrun);
    end
    drive(1'b1, 1);
    total++;
    if (bus.io_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drop: got valid=%b want 0", bus.io_valid);
    end
  endtask

  task automatic test_abort();
    do_reset();
    bus.io_en = 1'b1; bus.io_ready = 1'b0;
    tick();
    drive(1'b0, 2);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b1, 1);
    bus.io_en = 1'b0;
    tick();
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period} !== {1'b1, 9'd2, 9'd5}) begin
      bad++;
      $display("FAIL en_off_keep: got v=%b h=%0d p=%0d want v=1 h=2 p=5",
               bus.io_valid, bus.io_high, bus.io_period);
    end
    bus.io_ready = 1'b1;
    tick();
    bus.io_en = 1'b1;
    tick();
    drive(1'b0, 2);
    drive(1'b1, 1);
    total++;
    if (bus.io_valid !== 1'b0) begin
      bad++;
      $display("FAIL en_first_rise: got valid=%b want 0", bus.io_valid);
    end
    drive(1'b1, 2);
    drive(1'b0, 4);
    drive(1'b1, 1);
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period} !== {1'b1, 9'd3, 9'd7}) begin
      bad++;
      $display("FAIL en_second_rise: got v=%b h=%0d p=%0d want v=1 h=3 p=7",
               bus.io_valid, bus.io_high, bus.io_period);
    end
    // reset in the middle of a high phase with a result pending
    bus.io_ready = 1'b0;
    drive(1'b1, 1);
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b1, 1);
    do_reset();
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period} !== 19'd0) begin
      bad++;
      $display("FAIL rst_mid_high: got v=%b h=%0d p=%0d want 0",
               bus.io_valid, bus.io_high, bus.io_period);
    end
    tick();
    drive(1'b0, 2);
    drive(1'b1, 1);
    total++;
    if (bus.io_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_first_rise: got valid=%b want 0", bus.io_valid);
    end
    drive(1'b1, 3);
    drive(1'b0, 1);
    drive(1'b1, 1);
    total++;
    if ({bus.io_valid, bus.io_high, bus.io_period} !== {1'b1, 9'd4, 9'd5}) begin
      bad++;
      $display("FAIL rst_second_rise: got v=%b h=%0d p=%0d want v=1 h=4 p=5",
               bus.io_valid, bus.io_high, bus.io_period);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_period();
    test_stuck();
    test_overrun();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
